// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock,
// with start/busy/done handshake and overflow flag for undersized digit counts.
module bin_to_bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

  state_t            state_q, state_nxt;
  logic [WIDTH-1:0]  sh_q, sh_nxt;
  logic [BW-1:0]     scr_q, scr_adj, scr_nxt;
  logic [CW-1:0]     cnt_q;
  logic              sticky_q, sticky_nxt;
  logic              load, step, last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state and datapath controls
  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        step = 1'b1;
        if (cnt_q == CW'(1)) begin
          last      = 1'b1;
          state_nxt = FIN;
        end
      end
      FIN: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = CONV;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One double-dabble step: per-digit add-3, then shift the whole chain left
  always_comb begin
    scr_adj = scr_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (scr_q[4*k +: 4] >= 4'd5) scr_adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
    end
    scr_nxt    = {scr_adj[BW-2:0], sh_q[WIDTH-1]};
    sh_nxt     = {sh_q[WIDTH-2:0], 1'b0};
    sticky_nxt = sticky_q | scr_adj[BW-1];
  end

  // Conversion datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q     <= '0;
      scr_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      bcd      <= '0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (load) begin
        sh_q     <= bin;
        scr_q    <= '0;
        sticky_q <= 1'b0;
        cnt_q    <= CW'(WIDTH);
      end else if (step) begin
        sh_q     <= sh_nxt;
        scr_q    <= scr_nxt;
        sticky_q <= sticky_nxt;
        cnt_q    <= cnt_q - CW'(1);
      end
      if (last) begin
        bcd <= scr_nxt;
        ovf <= sticky_nxt;
      end
      busy <= (state_nxt == CONV);
      done <= (state_nxt == FIN);
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq across three parameter sets.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // a: WIDTH=4 DIGITS=2, b: WIDTH=8 DIGITS=3, c: WIDTH=8 DIGITS=2
  logic       start_a, start_b, start_c;
  logic [3:0] bin_a;
  logic [7:0] bin_b, bin_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic       ovf_a, ovf_b, ovf_c;
  logic [7:0] bcd_a, bcd_c;
  logic [11:0] bcd_b;

  bin_to_bcd_seq #(.WIDTH(4), .DIGITS(2)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .ovf(ovf_a));
  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .ovf(ovf_b));
  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .bin(bin_c),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .ovf(ovf_c));

  int checks = 0;
  int errors = 0;
  int sel = 1;
  int lat;

  logic        cur_busy, cur_done, cur_ovf;
  logic [31:0] cur_bcd;

  always_comb begin
    case (sel)
      0:       begin cur_busy = busy_a; cur_done = done_a; cur_ovf = ovf_a; cur_bcd = 32'(bcd_a); end
      2:       begin cur_busy = busy_c; cur_done = done_c; cur_ovf = ovf_c; cur_bcd = 32'(bcd_c); end
      default: begin cur_busy = busy_b; cur_done = done_b; cur_ovf = ovf_b; cur_bcd = 32'(bcd_b); end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int s, input logic st, input logic [31:0] v);
    case (s)
      0:       begin start_a = st; bin_a = v[3:0]; end
      2:       begin start_c = st; bin_c = v[7:0]; end
      default: begin start_b = st; bin_b = v[7:0]; end
    endcase
  endtask

  // Pulse start for one edge, then count edges until done (bounded)
  task automatic conv(input int s, input logic [31:0] v, output int n);
    sel = s;
    set_in(s, 1'b1, v);
    @(negedge clk);
    set_in(s, 1'b0, v);
    n = 0;
    while (cur_done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 0; start_b = 0; start_c = 0;
    bin_a = '0; bin_b = '0; bin_c = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_b), 32'd0);
    chk("rst_done", 32'(done_b), 32'd0);
    chk("rst_bcd", 32'(bcd_b), 32'd0);
    chk("rst_ovf", 32'(ovf_b), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_done", 32'(done_b), 32'd0);

    // Full sweep of the 4-bit converter
    for (int v = 0; v < 16; v++) begin
      conv(0, 32'(v), lat);
      chk("w4_lat", 32'(lat), 32'd4);
      chk("w4_bcd", cur_bcd, 32'(((v / 10) << 4) | (v % 10)));
      chk("w4_ovf", 32'(cur_ovf), 32'd0);
      @(negedge clk);
    end

    conv(1, 32'd255, lat);
    chk("b255_lat", 32'(lat), 32'd8);
    chk("b255_bcd", cur_bcd, 32'h255);
    chk("b255_ovf", 32'(cur_ovf), 32'd0);
    @(negedge clk);
    conv(1, 32'd0, lat);
    chk("b0_bcd", cur_bcd, 32'h000);
    @(negedge clk);
    conv(1, 32'd99, lat);
    chk("b99_bcd", cur_bcd, 32'h099);
    @(negedge clk);
    chk("b99_hold_done", 32'(cur_done), 32'd0);
    chk("b99_hold_bcd", cur_bcd, 32'h099);

    // Undersized digit count
    conv(2, 32'd150, lat);
    chk("c150_bcd", cur_bcd, 32'h50);
    chk("c150_ovf", 32'(cur_ovf), 32'd1);
    @(negedge clk);
    conv(2, 32'd99, lat);
    chk("c99_bcd", cur_bcd, 32'h99);
    chk("c99_ovf", 32'(cur_ovf), 32'd0);
    @(negedge clk);
    conv(2, 32'd100, lat);
    chk("c100_bcd", cur_bcd, 32'h00);
    chk("c100_ovf", 32'(cur_ovf), 32'd1);
    @(negedge clk);
    conv(2, 32'd255, lat);
    chk("c255_bcd", cur_bcd, 32'h55);
    chk("c255_ovf", 32'(cur_ovf), 32'd1);
    @(negedge clk);

    // start re-pulsed mid-conversion is ignored
    sel = 1;
    set_in(1, 1'b1, 32'd200);
    @(negedge clk);
    set_in(1, 1'b0, 32'd200);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      chk("ign_busy", 32'(cur_busy), 32'(i < 8));
      chk("ign_done", 32'(cur_done), 32'(i == 8));
      if (i == 3) set_in(1, 1'b1, 32'd7);
      if (i == 4) set_in(1, 1'b0, 32'd7);
    end
    chk("ign_bcd", cur_bcd, 32'h200);

    // start held high: back-to-back conversions
    set_in(1, 1'b1, 32'd123);
    @(negedge clk);
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      chk("b2b_done", 32'(cur_done), 32'(i == 8 || i == 17));
      if (i == 8)  chk("b2b_bcd0", cur_bcd, 32'h123);
      if (i == 17) chk("b2b_bcd1", cur_bcd, 32'h045);
      if (i == 1)  set_in(1, 1'b1, 32'd45);
      if (i == 17) set_in(1, 1'b0, 32'd45);
    end

    // Asynchronous reset mid-conversion
    set_in(1, 1'b1, 32'd200);
    @(negedge clk);
    set_in(1, 1'b0, 32'd200);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_b), 32'd0);
    chk("arst_done", 32'(done_b), 32'd0);
    chk("arst_bcd", 32'(bcd_b), 32'd0);
    chk("arst_ovf", 32'(ovf_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("arst_nodone", 32'(done_b), 32'd0);
    end
    conv(1, 32'd42, lat);
    chk("b42_lat", 32'(lat), 32'd8);
    chk("b42_bcd", cur_bcd, 32'h042);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
